// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_t;
    typedef enum logic [1:0] {NONE, FETCH, DATA} owner_t;

    localparam logic [63:0] ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester pick: fixed data priority, or round-robin on the last grant.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter int DATA_PRIO = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req_f,
    input  logic   i_req_d,
    input  logic   i_take,
    output owner_t o_pick
);

    logic r_last_d;

    always_comb begin
        o_pick = NONE;
        if (i_req_f && i_req_d) begin
            if (DATA_PRIO != 0 || !r_last_d) o_pick = DATA;
            else                             o_pick = FETCH;
        end else if (i_req_d) begin
            o_pick = DATA;
        end else if (i_req_f) begin
            o_pick = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b0;
        end else if (i_take && o_pick != NONE) begin
            r_last_d <= (o_pick == DATA);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and load/store.
//   IDLE      | no transaction; arbitrate and latch winner
//   REQ       | m_req high until m_gnt
//   WAIT_RESP | granted, waiting for m_rvalid or watchdog
//   RESP      | one-cycle response pulse to the owner
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_PRIO = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic        d_we,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic [63:0] m_addr,
    output logic [63:0] m_wdata,
    output logic        m_we,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [63:0] m_rdata,
    output logic        stray_rsp
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        r_state, w_state_nxt;
    owner_t        r_owner, w_pick;
    logic [CW-1:0] r_cnt, w_cnt_inc;
    logic [63:0]   r_addr, r_wdata, r_rdata;
    logic          r_we, r_err, r_stray;
    logic          w_take, w_capture, w_timeout, w_resp;

    rr_arb2 #(.DATA_PRIO(DATA_PRIO)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req_f (if_req),
        .i_req_d (d_req),
        .i_take  (w_take),
        .o_pick  (w_pick)
    );

    assign w_cnt_inc = r_cnt + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick != NONE) begin
                    w_state_nxt = REQ;
                    w_take      = 1'b1;
                end
            end
            REQ: begin
                if (m_gnt) begin
                    w_capture = m_rvalid;
                    if (m_rvalid) w_state_nxt = RESP;
                    else          w_state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (m_rvalid) begin
                    w_state_nxt = RESP;
                    w_capture   = 1'b1;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_state_nxt = RESP;
                    w_timeout   = 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_stray <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_owner <= w_pick;
                if (w_pick == DATA) begin
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                    r_we    <= d_we;
                end else begin
                    r_addr  <= if_addr;
                    r_wdata <= '0;
                    r_we    <= 1'b0;
                end
            end else if (r_state == RESP) begin
                r_owner <= NONE;
            end
            if (r_state == WAIT_RESP) r_cnt <= w_cnt_inc;
            else if (r_state == RESP) r_cnt <= '0;
            // store acknowledges carry no data
            if (w_capture) begin
                r_rdata <= r_we ? 64'd0 : m_rdata;
                r_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rdata <= ERR_RDATA;
                r_err   <= 1'b1;
            end
            if (m_rvalid && (r_state == IDLE || r_state == RESP || (r_state == REQ && !m_gnt)))
                r_stray <= 1'b1;
        end
    end

    assign w_resp    = (r_state == RESP);
    assign m_req     = (r_state == REQ);
    assign m_addr    = r_addr;
    assign m_wdata   = r_wdata;
    assign m_we      = r_we;
    assign stray_rsp = r_stray;

    assign if_gnt    = m_req && m_gnt && (r_owner == FETCH);
    assign d_gnt     = m_req && m_gnt && (r_owner == DATA);
    assign if_rvalid = w_resp && (r_owner == FETCH);
    assign d_rvalid  = w_resp && (r_owner == DATA);
    assign if_err    = if_rvalid && r_err;
    assign d_err     = d_rvalid && r_err;
    assign if_rdata  = if_rvalid ? (r_addr[2] ? r_rdata[63:32] : r_rdata[31:0]) : 32'd0;
    assign d_rdata   = d_rvalid ? r_rdata : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance 0 has data priority, instance 1 round-robin; both TIMEOUT=4.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req    [2];
    logic [63:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        if_err    [2];
    logic        d_req     [2];
    logic [63:0] d_addr    [2];
    logic [63:0] d_wdata   [2];
    logic        d_we      [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [63:0] d_rdata   [2];
    logic        d_err     [2];
    logic        m_req     [2];
    logic [63:0] m_addr    [2];
    logic [63:0] m_wdata   [2];
    logic        m_we      [2];
    logic        m_gnt     [2];
    logic        m_rvalid  [2];
    logic [63:0] m_rdata   [2];
    logic        stray_rsp [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.DATA_PRIO(g == 0 ? 1 : 0), .TIMEOUT(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .if_err    (if_err[g]),
            .d_req     (d_req[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_we      (d_we[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .d_err     (d_err[g]),
            .m_req     (m_req[g]),
            .m_addr    (m_addr[g]),
            .m_wdata   (m_wdata[g]),
            .m_we      (m_we[g]),
            .m_gnt     (m_gnt[g]),
            .m_rvalid  (m_rvalid[g]),
            .m_rdata   (m_rdata[g]),
            .stray_rsp (stray_rsp[g])
        );

        a_if_hold: assert property (@(posedge clk) disable iff (!rst)
            (if_req[g] && !if_gnt[g]) |=> if_req[g])
            else $error("protocol: if_req dropped before if_gnt");
        a_d_hold: assert property (@(posedge clk) disable iff (!rst)
            (d_req[g] && !d_gnt[g]) |=> d_req[g])
            else $error("protocol: d_req dropped before d_gnt");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory grants and answers in the same cycle; owner: 0 none, 1 fetch, 2 data.
    task automatic serve(input int idx, input logic [63:0] rd, output int owner,
                         output logic [63:0] addr, output logic [63:0] rdata);
        int n = 0;
        owner = 0;
        rdata = '0;
        while (!m_req[idx] && n < 10) begin
            tick();
            n++;
        end
        check_eq("serve_m_req", 64'(m_req[idx]), 64'd1);
        addr          = m_addr[idx];
        m_gnt[idx]    = 1'b1;
        m_rvalid[idx] = 1'b1;
        m_rdata[idx]  = rd;
        #1;
        if (if_gnt[idx])     owner = 1;
        else if (d_gnt[idx]) owner = 2;
        tick();
        m_gnt[idx]    = 1'b0;
        m_rvalid[idx] = 1'b0;
        if (owner == 1) begin
            if_req[idx] = 1'b0;
            check_eq("serve_if_rvalid", 64'(if_rvalid[idx]), 64'd1);
            rdata = {32'd0, if_rdata[idx]};
        end else if (owner == 2) begin
            d_req[idx] = 1'b0;
            check_eq("serve_d_rvalid", 64'(d_rvalid[idx]), 64'd1);
            rdata = d_rdata[idx];
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          owner, exp_first, last;
        logic [63:0] addr, rdata;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0;
            d_req[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0; d_we[i] = 1'b0;
            m_gnt[i] = 1'b0; m_rvalid[i] = 1'b0; m_rdata[i] = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_m_req", 64'(m_req[i]), 64'd0);
            check_eq("rst_m_addr", m_addr[i], 64'd0);
            check_eq("rst_stray", 64'(stray_rsp[i]), 64'd0);
            check_eq("rst_rvalid", 64'({if_rvalid[i], d_rvalid[i]}), 64'd0);
        end
        rst = 1'b1;
        tick();

        // fetch alone, gnt 2 cycles after m_req, rvalid 3 cycles after gnt
        if_req[0] = 1'b1; if_addr[0] = 64'h1004;
        tick();
        check_eq("t1_m_req", 64'(m_req[0]), 64'd1);
        check_eq("t1_m_addr", m_addr[0], 64'h1004);
        tick();
        check_eq("t1_gnt_early", 64'(if_gnt[0]), 64'd0);
        tick();
        m_gnt[0] = 1'b1;
        #1;
        check_eq("t1_if_gnt", 64'(if_gnt[0]), 64'd1);
        check_eq("t1_d_gnt", 64'(d_gnt[0]), 64'd0);
        tick();
        m_gnt[0] = 1'b0; if_req[0] = 1'b0;
        check_eq("t1_m_req_fall", 64'(m_req[0]), 64'd0);
        tick();
        tick();
        m_rvalid[0] = 1'b1; m_rdata[0] = 64'h1111_2222_3333_4444;
        #1;
        check_eq("t1_rvalid_early", 64'(if_rvalid[0]), 64'd0);
        tick();
        m_rvalid[0] = 1'b0;
        check_eq("t1_if_rvalid", 64'(if_rvalid[0]), 64'd1);
        check_eq("t1_if_rdata", 64'(if_rdata[0]), 64'h1111_2222);
        check_eq("t1_if_err", 64'(if_err[0]), 64'd0);
        check_eq("t1_d_idle", 64'({d_gnt[0], d_rvalid[0], d_err[0]}), 64'd0);
        check_eq("t1_d_rdata", d_rdata[0], 64'd0);
        tick();
        check_eq("t1_rvalid_end", 64'(if_rvalid[0]), 64'd0);

        // simultaneous requests with data priority
        if_req[0] = 1'b1; if_addr[0] = 64'h1000;
        d_req[0] = 1'b1; d_addr[0] = 64'h2000; d_we[0] = 1'b0;
        serve(0, 64'hA5A5_0000_5A5A_1111, owner, addr, rdata);
        check_eq("t2_owner1", 64'(owner), 64'd2);
        check_eq("t2_addr1", addr, 64'h2000);
        check_eq("t2_rdata1", rdata, 64'hA5A5_0000_5A5A_1111);
        serve(0, 64'h7777_8888_9999_AAAA, owner, addr, rdata);
        check_eq("t2_owner2", 64'(owner), 64'd1);
        check_eq("t2_addr2", addr, 64'h1000);
        check_eq("t2_rdata2", rdata, 64'h9999_AAAA);

        // round-robin instance, four rounds of simultaneous requests
        last = 1;
        for (int r = 0; r < 4; r++) begin
            if_req[1] = 1'b1; if_addr[1] = 64'h1000;
            d_req[1] = 1'b1; d_addr[1] = 64'h2000; d_we[1] = 1'b0;
            exp_first = (last == 1) ? 2 : 1;
            serve(1, 64'h0123_4567_89AB_CDEF, owner, addr, rdata);
            check_eq("t3_rr_first", 64'(owner), 64'(exp_first));
            serve(1, 64'h0123_4567_89AB_CDEF, owner, addr, rdata);
            check_eq("t3_rr_second", 64'(owner), 64'(3 - exp_first));
            last = 3 - exp_first;
        end

        // store, gnt and ack in the same cycle
        d_req[0] = 1'b1; d_addr[0] = 64'h3008; d_wdata[0] = 64'hDEAD_BEEF; d_we[0] = 1'b1;
        tick();
        check_eq("t4_m_we", 64'(m_we[0]), 64'd1);
        check_eq("t4_m_wdata", m_wdata[0], 64'hDEAD_BEEF);
        check_eq("t4_m_addr", m_addr[0], 64'h3008);
        m_gnt[0] = 1'b1; m_rvalid[0] = 1'b1; m_rdata[0] = 64'h5555_5555_5555_5555;
        #1;
        check_eq("t4_d_gnt", 64'(d_gnt[0]), 64'd1);
        check_eq("t4_rvalid_early", 64'(d_rvalid[0]), 64'd0);
        tick();
        m_gnt[0] = 1'b0; m_rvalid[0] = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
        check_eq("t4_d_rvalid", 64'(d_rvalid[0]), 64'd1);
        check_eq("t4_d_rdata", d_rdata[0], 64'd0);
        check_eq("t4_d_err", 64'(d_err[0]), 64'd0);
        tick();
        check_eq("t4_rvalid_end", 64'(d_rvalid[0]), 64'd0);

        // watchdog: memory grants but never answers
        d_req[0] = 1'b1; d_addr[0] = 64'h4000;
        tick();
        m_gnt[0] = 1'b1;
        #1;
        check_eq("t5_d_gnt", 64'(d_gnt[0]), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            m_gnt[0] = 1'b0; d_req[0] = 1'b0;
            check_eq("t5_wait_no_rvalid", 64'(d_rvalid[0]), 64'd0);
        end
        tick();
        check_eq("t5_d_rvalid", 64'(d_rvalid[0]), 64'd1);
        check_eq("t5_d_err", 64'(d_err[0]), 64'd1);
        check_eq("t5_d_rdata", d_rdata[0], 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("t5_no_stray_yet", 64'(stray_rsp[0]), 64'd0);
        tick();
        m_rvalid[0] = 1'b1;
        #1;
        check_eq("t5_late_no_rvalid", 64'(d_rvalid[0]), 64'd0);
        tick();
        m_rvalid[0] = 1'b0;
        check_eq("t5_stray", 64'(stray_rsp[0]), 64'd1);
        check_eq("t5_late_dropped", 64'(d_rvalid[0]), 64'd0);

        // asynchronous reset in WAIT_RESP
        d_req[0] = 1'b1; d_addr[0] = 64'h5000;
        tick();
        m_gnt[0] = 1'b1;
        tick();
        m_gnt[0] = 1'b0; d_req[0] = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_m_req", 64'(m_req[0]), 64'd0);
        check_eq("t6_m_addr", m_addr[0], 64'd0);
        check_eq("t6_stray", 64'(stray_rsp[0]), 64'd0);
        check_eq("t6_outs", 64'({d_gnt[0], d_rvalid[0], d_err[0], if_rvalid[0], m_we[0]}), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        if_req[0] = 1'b1; if_addr[0] = 64'h1000;
        serve(0, 64'hAAAA_BBBB_CCCC_DDDD, owner, addr, rdata);
        check_eq("t6_owner", 64'(owner), 64'd1);
        check_eq("t6_rdata", rdata, 64'hCCCC_DDDD);
        check_eq("t6_stray_after", 64'(stray_rsp[0]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
